// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared constants and types for the register-file write-back
//               block. It defines the data and index widths, the buffered
//               entry type {rd, data}, and the producer-source selector.
//               Optional feature macro: WB_BYPASS_EN (see regfile_writeback).
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int NUM_REGISTERS = 32;
    localparam int REG_IDX_WIDTH = $clog2(NUM_REGISTERS);

    typedef struct packed {
        logic [REG_IDX_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU,
        WB_SRC_LOAD
    } wb_src_t;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback_if
// Description : Bundles the producer handshakes (ALU and load), the
//               register-file write port and the scoreboard outputs of
//               regfile_writeback.
//               master : the write-back block itself
//               slave  : producers, register file and decode (environment)
//               With WB_BYPASS_EN defined, the interface also carries the two
//               operand-forwarding read ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_writeback_if;
    import wb_pkg::*;

    logic                     alu_valid;
    logic                     alu_ready;
    logic [REG_IDX_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]    alu_data;

    logic                     load_valid;
    logic                     load_ready;
    logic [REG_IDX_WIDTH-1:0] load_rd;
    logic [DATA_WIDTH-1:0]    load_data;

    logic [REG_IDX_WIDTH-1:0] write_register;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     write_activate;
    logic                     write_done;

    logic [NUM_REGISTERS-1:0] pending;
    logic                     idle;

`ifdef WB_BYPASS_EN
    logic [REG_IDX_WIDTH-1:0] rd_idx_1;
    logic [REG_IDX_WIDTH-1:0] rd_idx_2;
    logic [DATA_WIDTH-1:0]    rf_result_1;
    logic [DATA_WIDTH-1:0]    rf_result_2;
    logic [DATA_WIDTH-1:0]    fwd_result_1;
    logic [DATA_WIDTH-1:0]    fwd_result_2;
`endif

    modport master (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  load_valid, load_rd, load_data,
        output load_ready,
        output write_register, write_data, write_activate,
        input  write_done,
        output pending, idle
`ifdef WB_BYPASS_EN
        ,
        input  rd_idx_1, rd_idx_2, rf_result_1, rf_result_2,
        output fwd_result_1, fwd_result_2
`endif
    );

    modport slave (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output load_valid, load_rd, load_data,
        input  load_ready,
        input  write_register, write_data, write_activate,
        output write_done,
        input  pending, idle
`ifdef WB_BYPASS_EN
        ,
        output rd_idx_1, rd_idx_2, rf_result_1, rf_result_2,
        input  fwd_result_1, fwd_result_2
`endif
    );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : In-order FIFO of wb_entry_t. Besides head/full/empty/count it
//               exposes every slot in age order (index 0 = oldest) with a
//               valid flag, so the parent can build a scoreboard and, with
//               WB_BYPASS_EN defined, a forwarding network.
// Ports       : clk, rst_n (async, active-low), push/push_entry, pop,
//               full, empty, count, head_rd/head_data (0 when empty),
//               ord_valid/ord_rd (and ord_data with WB_BYPASS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push,
    input  wb_entry_t                             push_entry,
    input  logic                                  pop,
    output logic                                  full,
    output logic                                  empty,
    output logic [$clog2(DEPTH+1)-1:0]            count,
    output logic [REG_IDX_WIDTH-1:0]              head_rd,
    output logic [DATA_WIDTH-1:0]                 head_data,
    output logic [DEPTH-1:0]                      ord_valid,
    output logic [DEPTH-1:0][REG_IDX_WIDTH-1:0]   ord_rd
`ifdef WB_BYPASS_EN
    ,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]      ord_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: every read path is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_rd   = empty ? '0 : mem[rd_ptr].rd;
    assign head_data = empty ? '0 : mem[rd_ptr].data;

    for (genvar k = 0; k < DEPTH; k++) begin : g_ord
        logic [PTR_W-1:0] slot;
        assign slot         = rd_ptr + PTR_W'(k);
        assign ord_valid[k] = (CNT_W'(k) < count);
        assign ord_rd[k]    = mem[slot].rd;
`ifdef WB_BYPASS_EN
        assign ord_data[k]  = mem[slot].data;
`endif
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                    count <= CNT_W'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(pop && empty));

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : Write-port initiator for the 32x32 register file. Results
//               from the ALU and the load unit are buffered in an in-order
//               FIFO and retired one per write_done. A pending-write
//               scoreboard is exported for RAW stall detection.
//               Load has fixed priority over ALU; rd=0 results are consumed
//               but never buffered.
// Ports       : clk, rst_n (async, active-low), wb (regfile_writeback_if
//               master modport: ALU/load handshakes, write port, pending,
//               idle).
// Option      : WB_BYPASS_EN adds two combinational forwarding read ports
//               (rd_idx_n / rf_result_n -> fwd_result_n).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_writeback_if.master  wb
);

    localparam int CNT_W = $clog2(FIFO_DEPTH+1);

    logic                                      full;
    logic                                      empty;
    logic [CNT_W-1:0]                          count;
    logic [REG_IDX_WIDTH-1:0]                  head_rd;
    logic [DATA_WIDTH-1:0]                     head_data;
    logic [FIFO_DEPTH-1:0]                     ord_valid;
    logic [FIFO_DEPTH-1:0][REG_IDX_WIDTH-1:0]  ord_rd;
`ifdef WB_BYPASS_EN
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]     ord_data;
`endif

    logic               load_ready;
    logic               alu_ready;
    logic               accept;
    logic               push;
    logic               pop;
    wb_src_t            src;
    wb_entry_t          push_entry;
    logic [NUM_REGISTERS-1:0] pending_vec;

    // Ready is a function of registered occupancy only; a pop in the same
    // cycle does not free a slot early. rst_n gates it low during reset.
    assign load_ready = rst_n && !full;
    assign alu_ready  = rst_n && !full && !wb.load_valid;

    assign src    = wb.load_valid ? WB_SRC_LOAD : WB_SRC_ALU;
    assign accept = (wb.load_valid && load_ready) || (wb.alu_valid && alu_ready);

    always_comb begin
        push_entry = '{rd: wb.alu_rd, data: wb.alu_data};
        if (src == WB_SRC_LOAD) begin
            push_entry = '{rd: wb.load_rd, data: wb.load_data};
        end
    end

    // x0 writes complete their handshake but are dropped here.
    assign push = accept && (push_entry.rd != '0);
    assign pop  = !empty && wb.write_done;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .ord_valid  (ord_valid),
        .ord_rd     (ord_rd)
`ifdef WB_BYPASS_EN
        ,
        .ord_data   (ord_data)
`endif
    );

    always_comb begin
        pending_vec = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (ord_valid[k]) pending_vec[ord_rd[k]] = 1'b1;
        end
        pending_vec[0] = 1'b0;
    end

    assign wb.alu_ready      = alu_ready;
    assign wb.load_ready     = load_ready;
    assign wb.write_activate = !empty;
    assign wb.write_register = head_rd;
    assign wb.write_data     = head_data;
    assign wb.pending        = pending_vec;
    assign wb.idle           = (count == '0);

`ifdef WB_BYPASS_EN
    logic [DATA_WIDTH-1:0] fwd_1;
    logic [DATA_WIDTH-1:0] fwd_2;

    // Slots are scanned oldest to youngest, so the last match wins and the
    // youngest buffered value for a register is forwarded.
    always_comb begin
        fwd_1 = wb.rf_result_1;
        fwd_2 = wb.rf_result_2;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (ord_valid[k] && (ord_rd[k] == wb.rd_idx_1)) fwd_1 = ord_data[k];
            if (ord_valid[k] && (ord_rd[k] == wb.rd_idx_2)) fwd_2 = ord_data[k];
        end
        if (wb.rd_idx_1 == '0) fwd_1 = '0;
        if (wb.rd_idx_2 == '0) fwd_2 = '0;
    end

    assign wb.fwd_result_1 = fwd_1;
    assign wb.fwd_result_2 = fwd_2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback
// Description : Directed self-checking bench for regfile_writeback with
//               hand-computed expected values. Covers WB_BYPASS_EN
//               forwarding when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;
    import wb_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    regfile_writeback_if wb_bus ();

    regfile_writeback #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks run 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int exp_rd [4];
        checks = 0;
        errors = 0;

        rst_n             = 1'b0;
        wb_bus.alu_valid  = 1'b0;
        wb_bus.alu_rd     = '0;
        wb_bus.alu_data   = '0;
        wb_bus.load_valid = 1'b0;
        wb_bus.load_rd    = '0;
        wb_bus.load_data  = '0;
        wb_bus.write_done = 1'b0;
`ifdef WB_BYPASS_EN
        wb_bus.rd_idx_1    = '0;
        wb_bus.rd_idx_2    = '0;
        wb_bus.rf_result_1 = '0;
        wb_bus.rf_result_2 = '0;
`endif

        // Reset state
        #3;
        check_value("rst_alu_ready",  64'(wb_bus.alu_ready), 64'd0);
        check_value("rst_load_ready", 64'(wb_bus.load_ready), 64'd0);
        check_value("rst_idle",       64'(wb_bus.idle), 64'd1);
        check_value("rst_wact",       64'(wb_bus.write_activate), 64'd0);
        check_value("rst_wreg",       64'(wb_bus.write_register), 64'd0);
        check_value("rst_wdata",      64'(wb_bus.write_data), 64'd0);
        check_value("rst_pending",    64'(wb_bus.pending), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        check_value("post_rst_load_ready", 64'(wb_bus.load_ready), 64'd1);

        // Single ALU push with write_done tied high (also idle while empty)
        wb_bus.write_done = 1'b1;
        wb_bus.alu_valid  = 1'b1;
        wb_bus.alu_rd     = 5'd5;
        wb_bus.alu_data   = 32'hDEADBEEF;
        settle();
        check_value("t1_alu_ready", 64'(wb_bus.alu_ready), 64'd1);
        tick();
        wb_bus.alu_valid = 1'b0;
        settle();
        check_value("t1_wact",    64'(wb_bus.write_activate), 64'd1);
        check_value("t1_wreg",    64'(wb_bus.write_register), 64'd5);
        check_value("t1_wdata",   64'(wb_bus.write_data), 64'hDEADBEEF);
        check_value("t1_pending", 64'(wb_bus.pending), 64'h20);
        check_value("t1_busy",    64'(wb_bus.idle), 64'd0);
        tick();
        check_value("t1_idle",      64'(wb_bus.idle), 64'd1);
        check_value("t1_pending0",  64'(wb_bus.pending), 64'd0);
        check_value("t1_wact_done", 64'(wb_bus.write_activate), 64'd0);

        // Simultaneous ALU and load offers: load wins
        wb_bus.write_done = 1'b0;
        wb_bus.alu_valid  = 1'b1;
        wb_bus.alu_rd     = 5'd3;
        wb_bus.alu_data   = 32'h33;
        wb_bus.load_valid = 1'b1;
        wb_bus.load_rd    = 5'd4;
        wb_bus.load_data  = 32'h44;
        settle();
        check_value("t2_load_ready", 64'(wb_bus.load_ready), 64'd1);
        check_value("t2_alu_ready",  64'(wb_bus.alu_ready), 64'd0);
        tick();
        wb_bus.load_valid = 1'b0;
        settle();
        check_value("t2_alu_ready2", 64'(wb_bus.alu_ready), 64'd1);
        tick();
        wb_bus.alu_valid = 1'b0;
        settle();
        check_value("t2_head0_reg",  64'(wb_bus.write_register), 64'd4);
        check_value("t2_head0_data", 64'(wb_bus.write_data), 64'h44);
        check_value("t2_pending",    64'(wb_bus.pending), 64'h18);
        wb_bus.write_done = 1'b1;
        tick();
        check_value("t2_head1_reg",  64'(wb_bus.write_register), 64'd3);
        check_value("t2_head1_data", 64'(wb_bus.write_data), 64'h33);
        tick();
        wb_bus.write_done = 1'b0;
        settle();
        check_value("t2_idle", 64'(wb_bus.idle), 64'd1);

        // Fill to full, stall a 5th offer, single pop, then drain in order
        wb_bus.alu_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wb_bus.alu_rd   = 5'(i);
            wb_bus.alu_data = 32'hA0 + 32'(i);
            tick();
        end
        wb_bus.alu_rd   = 5'd6;
        wb_bus.alu_data = 32'hA6;
        settle();
        check_value("t3_full_alu_ready",  64'(wb_bus.alu_ready), 64'd0);
        check_value("t3_full_load_ready", 64'(wb_bus.load_ready), 64'd0);
        check_value("t3_full_pending",    64'(wb_bus.pending), 64'h1E);
        check_value("t3_full_head",       64'(wb_bus.write_register), 64'd1);
        tick();
        check_value("t3_stall_head",  64'(wb_bus.write_register), 64'd1);
        check_value("t3_stall_ready", 64'(wb_bus.alu_ready), 64'd0);
        wb_bus.write_done = 1'b1;
        tick();
        wb_bus.write_done = 1'b0;
        settle();
        check_value("t3_ready_back", 64'(wb_bus.alu_ready), 64'd1);
        check_value("t3_after_pop",  64'(wb_bus.write_register), 64'd2);
        tick();
        wb_bus.alu_valid  = 1'b0;
        wb_bus.write_done = 1'b1;
        exp_rd = '{2, 3, 4, 6};
        for (int i = 0; i < 4; i++) begin
            settle();
            check_value("t3_drain_reg", 64'(wb_bus.write_register), 64'(exp_rd[i]));
            tick();
        end
        wb_bus.write_done = 1'b0;
        settle();
        check_value("t3_drain_idle", 64'(wb_bus.idle), 64'd1);

        // x0 result is consumed but never buffered
        wb_bus.alu_valid = 1'b1;
        wb_bus.alu_rd    = 5'd0;
        wb_bus.alu_data  = 32'h1234;
        settle();
        check_value("t4_x0_ready", 64'(wb_bus.alu_ready), 64'd1);
        tick();
        wb_bus.alu_valid = 1'b0;
        settle();
        check_value("t4_x0_idle", 64'(wb_bus.idle), 64'd1);
        check_value("t4_x0_wact", 64'(wb_bus.write_activate), 64'd0);
        tick();
        check_value("t4_x0_wact2", 64'(wb_bus.write_activate), 64'd0);

        // Asynchronous reset with three buffered entries
        wb_bus.load_valid = 1'b1;
        for (int i = 8; i <= 10; i++) begin
            wb_bus.load_rd   = 5'(i);
            wb_bus.load_data = 32'hB0 + 32'(i);
            tick();
        end
        wb_bus.load_valid = 1'b0;
        settle();
        check_value("t5_pending_pre", 64'(wb_bus.pending), 64'h700);
        #2 rst_n = 1'b0;
        #1;
        check_value("t5_rst_wact",    64'(wb_bus.write_activate), 64'd0);
        check_value("t5_rst_pending", 64'(wb_bus.pending), 64'd0);
        check_value("t5_rst_idle",    64'(wb_bus.idle), 64'd1);
        check_value("t5_rst_ready",   64'(wb_bus.load_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        wb_bus.write_done = 1'b1;
        tick();
        check_value("t5_post_wact", 64'(wb_bus.write_activate), 64'd0);
        tick();
        check_value("t5_post_idle", 64'(wb_bus.idle), 64'd1);
        wb_bus.write_done = 1'b0;

`ifdef WB_BYPASS_EN
        // Forwarding picks the youngest buffered value
        wb_bus.alu_valid   = 1'b1;
        wb_bus.alu_rd      = 5'd7;
        wb_bus.alu_data    = 32'h11;
        tick();
        wb_bus.alu_data    = 32'h22;
        tick();
        wb_bus.alu_valid   = 1'b0;
        wb_bus.rd_idx_1    = 5'd7;
        wb_bus.rf_result_1 = 32'h99;
        wb_bus.rd_idx_2    = 5'd0;
        wb_bus.rf_result_2 = 32'h55;
        settle();
        check_value("t6_fwd1_young", 64'(wb_bus.fwd_result_1), 64'h22);
        check_value("t6_fwd2_x0",    64'(wb_bus.fwd_result_2), 64'h0);
        wb_bus.rd_idx_2 = 5'd9;
        settle();
        check_value("t6_fwd2_rf",    64'(wb_bus.fwd_result_2), 64'h55);
        wb_bus.write_done = 1'b1;
        tick();
        tick();
        wb_bus.write_done = 1'b0;
        settle();
        check_value("t6_fwd1_drained", 64'(wb_bus.fwd_result_1), 64'h99);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
